// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
//   Shared field layout for the pipelined CPU's inter-stage registers.
//   - Field widths used across all stages.
//   - Bundle widths and bit offsets for the ID/EX, EX/MEM and MEM/WB
//     control and data bundles.
//   The stage register itself treats the bundles as opaque. These constants
//   are for the stages that pack the bundles and unpack them again.
package cpu_pipe_pkg;

    // Basic field widths
    localparam int ALUOP_W    = 4;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int OPCODE_W   = 6;
    localparam int FUNCT_W    = 6;
    localparam int SHAMT_W    = 5;

    // ID/EX control bundle (LSB first)
    localparam int IDEX_REGDST    = 0;
    localparam int IDEX_ALUOP_LSB = 1;
    localparam int IDEX_ALUSRCB   = IDEX_ALUOP_LSB + ALUOP_W;
    localparam int IDEX_ALUSRCA   = IDEX_ALUSRCB + 1;
    localparam int IDEX_MEMWRITE  = IDEX_ALUSRCA + 1;
    localparam int IDEX_MEMREAD   = IDEX_MEMWRITE + 1;
    localparam int IDEX_REGDATA   = IDEX_MEMREAD + 1;
    localparam int IDEX_REGWRITE  = IDEX_REGDATA + 1;
    localparam int IDEX_CTRL_W    = IDEX_REGWRITE + 1;     // 11

    // ID/EX data bundle (LSB first)
    localparam int IDEX_RD_LSB    = 0;
    localparam int IDEX_RT_LSB    = IDEX_RD_LSB + REG_ADDR_W;
    localparam int IDEX_RS_LSB    = IDEX_RT_LSB + REG_ADDR_W;
    localparam int IDEX_FUNCT_LSB = IDEX_RS_LSB + REG_ADDR_W;
    localparam int IDEX_IMM_LSB   = IDEX_FUNCT_LSB + FUNCT_W;
    localparam int IDEX_SHAMT_LSB = IDEX_IMM_LSB + WORD_W;
    localparam int IDEX_R2_LSB    = IDEX_SHAMT_LSB + SHAMT_W;
    localparam int IDEX_R1_LSB    = IDEX_R2_LSB + WORD_W;
    localparam int IDEX_OP_LSB    = IDEX_R1_LSB + WORD_W;
    localparam int IDEX_DATA_W    = IDEX_OP_LSB + OPCODE_W; // 128

    // EX/MEM control bundle
    localparam int EXMEM_MEMWRITE = 0;
    localparam int EXMEM_MEMREAD  = 1;
    localparam int EXMEM_REGDATA  = 2;
    localparam int EXMEM_REGWRITE = 3;
    localparam int EXMEM_CTRL_W   = 4;

    // EX/MEM data bundle: dest reg, store data, ALU result
    localparam int EXMEM_RD_LSB    = 0;
    localparam int EXMEM_STORE_LSB = EXMEM_RD_LSB + REG_ADDR_W;
    localparam int EXMEM_ALU_LSB   = EXMEM_STORE_LSB + WORD_W;
    localparam int EXMEM_DATA_W    = EXMEM_ALU_LSB + WORD_W; // 69

    // MEM/WB control bundle
    localparam int MEMWB_REGDATA  = 0;
    localparam int MEMWB_REGWRITE = 1;
    localparam int MEMWB_CTRL_W   = 2;

    // MEM/WB data bundle: dest reg, ALU result, load data
    localparam int MEMWB_RD_LSB  = 0;
    localparam int MEMWB_ALU_LSB = MEMWB_RD_LSB + REG_ADDR_W;
    localparam int MEMWB_MEM_LSB = MEMWB_ALU_LSB + WORD_W;
    localparam int MEMWB_DATA_W  = MEMWB_MEM_LSB + WORD_W;   // 69

    // Typed view of the ID/EX control bundle. Member order matches the
    // offsets above, so reg_dst lands on bit 0.
    typedef struct packed {
        logic               reg_write;
        logic               reg_data;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src_a;
        logic               alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_dst;
    } idex_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One pipeline entry: a valid bit, a control bundle and a data bundle.
//   clear has priority over load. A cleared slot holds a bubble: valid=0
//   and ctrl=0. Its data keeps its last value because downstream never
//   looks at data without control.
// Ports
//   clk, rst         clock, async active-high reset (zeroes everything)
//   load             capture load_ctrl/load_data and set valid
//   clear            drop the entry (valid=0, ctrl=0, data held)
//   load_ctrl/data   values to capture
//   valid/ctrl/data  current slot contents
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic valid/ready register between two pipeline stages.
//   - SKID=1: a main slot plus a skid slot, with in_ready taken from a
//     flop so back-pressure does not ripple combinationally upstream.
//   - SKID=0: a single slot, with in_ready = out_ready || !out_valid.
//   flush kills every held entry and the incoming beat. out_ctrl is zero
//   whenever out_valid is low. stall_cnt counts cycles with out_valid=1
//   and out_ready=0, and saturates at all-ones.
// Ports
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     upstream handshake
//   in_ctrl/in_data       upstream bundles
//   out_valid/out_ready   downstream handshake
//   out_ctrl/out_data     downstream bundles
//   flush                 synchronous kill of all entries
//   stall_cnt             saturating stall-cycle counter
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              in_xfer;
    logic              out_xfer;

    // Main (output) slot controls. The mode branch below drives them.
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid && out_ready;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clear     (main_clear),
        .load_ctrl (main_ctrl_d),
        .load_data (main_data_d),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .data      (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              ready_q;

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_ctrl (in_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );

            // While skid is occupied, in_ready is low, so no input transfer
            // can happen. The only move left is to promote skid into main
            // once main drains. With skid empty, a beat that arrives while
            // main is stuck parks in skid, and every other beat goes
            // straight to main. This includes the case where main drains
            // in the same cycle, so no bubble is inserted.
            always_comb begin
                main_load   = 1'b0;
                main_clear  = 1'b0;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
                skid_load   = 1'b0;
                skid_clear  = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else if (skid_valid) begin
                    if (out_xfer) begin
                        main_load   = 1'b1;
                        main_ctrl_d = skid_ctrl;
                        main_data_d = skid_data;
                        skid_clear  = 1'b1;
                    end
                end else if (in_xfer) begin
                    if (main_valid && !out_ready) begin
                        skid_load = 1'b1;
                    end else begin
                        main_load = 1'b1;
                    end
                end else if (out_xfer) begin
                    main_clear = 1'b1;
                end
            end

            // in_ready registers the next-state emptiness of skid. It comes
            // out of reset high, so a beat can be taken on the first edge
            // after release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= !(skid_load || (skid_valid && !skid_clear));
                end
            end

            assign in_ready = ready_q;
        end else begin : g_single
            assign in_ready    = out_ready || !main_valid;
            assign main_ctrl_d = in_ctrl;
            assign main_data_d = in_data;
            assign main_load   = in_xfer && !flush;
            assign main_clear  = flush || (out_xfer && !in_xfer);
        end
    endgenerate

    // Stall counter: counts cycles where downstream refuses a valid beat.
    // It stops at all-ones instead of wrapping, and only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives three instances from the same stimulus: SKID=1/CNT_W=16,
//   SKID=0/CNT_W=16, and SKID=1/CNT_W=4. Expected values come from a
//   queue-based reference. Each stage holds an ordered list of at most
//   2 entries (skid) or 1 entry (single). The output shows the list head.
module tb_pipe_stage_reg;
    localparam int CW = 11;
    localparam int DW = 128;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic r1, v1, r0, v0, r4, v4;
    logic [CW-1:0] c1, c0, c4;
    logic [DW-1:0] d1, d0, d4;
    logic [15:0]   s1, s0;
    logic [3:0]    s4;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v1),
        .out_ready(out_ready), .out_ctrl(c1), .out_data(d1),
        .flush(flush), .stall_cnt(s1));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v0),
        .out_ready(out_ready), .out_ctrl(c0), .out_data(d0),
        .flush(flush), .stall_cnt(s0));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v4),
        .out_ready(out_ready), .out_ctrl(c4), .out_data(d4),
        .flush(flush), .stall_cnt(s4));

    // Reference state
    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] md1 = '0;
    logic [DW-1:0] md0 = '0;
    int            cnt1 = 0, cnt0 = 0, cnt4 = 0;
    int            total = 0, bad = 0;

    task automatic model_reset();
        q1.delete();
        q0.delete();
        md1 = '0;
        md0 = '0;
        cnt1 = 0;
        cnt0 = 0;
        cnt4 = 0;
    endtask

    // Advance one clock edge. The reference samples inputs just before the
    // edge: pop the head if downstream takes it, then append the incoming
    // beat if there is room. A flush empties the list instead.
    task automatic tick();
        ent_t e;
        bit   acc1, acc0, pop1, pop0;
        e.c  = in_ctrl;
        e.d  = in_data;
        acc1 = in_valid && (q1.size() < 2);
        acc0 = in_valid && (out_ready || q0.size() == 0);
        pop1 = out_ready && (q1.size() > 0);
        pop0 = out_ready && (q0.size() > 0);
        if (q1.size() > 0 && !out_ready) begin
            if (cnt1 < 65535) cnt1++;
            if (cnt4 < 15) cnt4++;
        end
        if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) q1.delete(0);
            if (acc1) q1.push_back(e);
            if (pop0) q0.delete(0);
            if (acc0) q0.push_back(e);
        end
        if (q1.size() > 0) md1 = q1[0].d;
        if (q0.size() > 0) md0 = q0[0].d;
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        logic [DW-1:0] ones;
        ones = '1;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 11'h7FF, ones);
        repeat (2) @(posedge clk);
        #1;
        total++; if (v1 !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %0h want 0", v1); end
        total++; if (c1 !== '0)    begin bad++; $display("FAIL reset_ctrl: got %0h want 0", c1); end
        total++; if (d1 !== '0)    begin bad++; $display("FAIL reset_data: got %0h want 0", d1); end
        total++; if (s1 !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", s1); end
        total++; if (v0 !== 1'b0 || d0 !== '0) begin bad++; $display("FAIL reset_single: got v=%0h d=%0h want 0", v0, d0); end
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0h want 1", r1); end
        tick();
        total++; if (v1 !== 1'b1 || c1 !== 11'h7FF) begin bad++; $display("FAIL reset_first_xfer: got v=%0h c=%0h want v=1 c=7ff", v1, c1); end
        total++; if (d1 !== ones) begin bad++; $display("FAIL reset_first_data: got %0h want %0h", d1, ones); end
        total++; if (v0 !== 1'b1 || c0 !== 11'h7FF) begin bad++; $display("FAIL reset_first_single: got v=%0h c=%0h want v=1 c=7ff", v0, c0); end
        drive(1'b0, '0, '0);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CW'(i), DW'(i));
            tick();
            total++; if (v1 !== 1'b1 || c1 !== CW'(i)) begin bad++; $display("FAIL stream_ctrl%0d: got v=%0h c=%0h want v=1 c=%0h", i, v1, c1, i); end
            total++; if (d1 !== DW'(i)) begin bad++; $display("FAIL stream_data%0d: got %0h want %0h", i, d1, i); end
            total++; if (r1 !== 1'b1)   begin bad++; $display("FAIL stream_ready%0d: got %0h want 1", i, r1); end
        end
        drive(1'b0, '0, '0);
        tick();
        total++; if (v1 !== 1'b0 || c1 !== '0) begin bad++; $display("FAIL stream_bubble: got v=%0h c=%0h want 0", v1, c1); end
        total++; if (d1 !== DW'(4)) begin bad++; $display("FAIL stream_hold_data: got %0h want 4", d1); end
        total++; if (s1 !== 16'd0)  begin bad++; $display("FAIL stream_stall: got %0d want 0", s1); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 11'h0A1, 128'hA);
        tick();
        drive(1'b1, 11'h0B2, 128'hB);
        #1;
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL bp_ready_before_skid: got %0h want 1", r1); end
        tick();
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL bp_ready_drop: got %0h want 0", r1); end
        drive(1'b0, '0, '0);
        tick();
        tick();
        total++; if (c1 !== 11'h0A1 || d1 !== 128'hA) begin bad++; $display("FAIL bp_hold_a: got c=%0h d=%0h want c=a1 d=a", c1, d1); end
        total++; if (s1 !== 16'd3) begin bad++; $display("FAIL bp_stall: got %0d want 3", s1); end
        out_ready = 1'b1;
        tick();
        total++; if (v1 !== 1'b1 || c1 !== 11'h0B2 || d1 !== 128'hB) begin bad++; $display("FAIL bp_emit_b: got v=%0h c=%0h d=%0h want b", v1, c1, d1); end
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %0h want 1", r1); end
        tick();
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL bp_drained: got %0h want 0", v1); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 11'h111, 128'h1111);
        tick();
        drive(1'b1, 11'h222, 128'h2222);
        tick();
        drive(1'b1, 11'h333, 128'h3333);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        total++; if (v1 !== 1'b0 || c1 !== '0) begin bad++; $display("FAIL flush_bubble: got v=%0h c=%0h want 0", v1, c1); end
        total++; if (d1 !== 128'h1111) begin bad++; $display("FAIL flush_data_held: got %0h want 1111", d1); end
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL flush_ready: got %0h want 1", r1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (v1 !== 1'b0 || v0 !== 1'b0) begin bad++; $display("FAIL flush_no_emit%0d: got v1=%0h v0=%0h want 0", i, v1, v0); end
        end
    endtask

    task automatic test_single_entry();
        out_ready = 1'b0;
        drive(1'b1, 11'h0C1, 128'hC1);
        #1;
        total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_ready_empty: got %0h want 1", r0); end
        tick();
        out_ready = 1'b1;
        drive(1'b1, 11'h0D2, 128'hD2);
        #1;
        total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_ready_comb: got %0h want 1", r0); end
        tick();
        total++; if (v0 !== 1'b1 || c0 !== 11'h0D2 || d0 !== 128'hD2) begin bad++; $display("FAIL single_replace: got v=%0h c=%0h d=%0h want d2", v0, c0, d0); end
        out_ready = 1'b0;
        drive(1'b1, 11'h0E3, 128'hE3);
        #1;
        total++; if (r0 !== 1'b0) begin bad++; $display("FAIL single_ready_blocked: got %0h want 0", r0); end
        tick();
        total++; if (c0 !== 11'h0D2) begin bad++; $display("FAIL single_hold: got %0h want d2", c0); end
        drive(1'b0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        drive(1'b1, 11'h055, 128'h55);
        for (int i = 0; i < 20; i++) tick();
        total++; if (s4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4: got %0d want 15", s4); end
        total++; if (s1 !== 16'(cnt1)) begin bad++; $display("FAIL sat_cnt16: got %0d want %0d", s1, cnt1); end
        drive(1'b0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (s4 !== 4'd15) begin bad++; $display("FAIL sat_after_flush: got %0d want 15", s4); end
        // Refill both slots, then reset mid-operation.
        drive(1'b1, 11'h066, 128'h66);
        tick();
        tick();
        drive(1'b0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (s4 !== 4'd0 || s1 !== 16'd0) begin bad++; $display("FAIL rst_clears_cnt: got s4=%0d s1=%0d want 0", s4, s1); end
        total++; if (v1 !== 1'b0 || c1 !== '0 || d1 !== '0) begin bad++; $display("FAIL rst_mid_op: got v=%0h c=%0h d=%0h want 0", v1, c1, d1); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (v1 !== 1'b0 || r1 !== 1'b1) begin bad++; $display("FAIL rst_skid_dropped: got v=%0h r=%0h want v=0 r=1", v1, r1); end
    endtask

    task automatic test_random();
        logic          ev1, ev0, er1, er0;
        logic [CW-1:0] ec1, ec0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            ev1 = q1.size() > 0;
            ev0 = q0.size() > 0;
            ec1 = ev1 ? q1[0].c : '0;
            ec0 = ev0 ? q0[0].c : '0;
            er1 = q1.size() < 2;
            er0 = out_ready || !ev0;
            total++; if (v1 !== ev1 || c1 !== ec1) begin bad++; $display("FAIL rnd_out1 @%0d: got v=%0h c=%0h want v=%0h c=%0h", n, v1, c1, ev1, ec1); end
            total++; if (d1 !== md1) begin bad++; $display("FAIL rnd_data1 @%0d: got %0h want %0h", n, d1, md1); end
            total++; if (r1 !== er1) begin bad++; $display("FAIL rnd_ready1 @%0d: got %0h want %0h", n, r1, er1); end
            total++; if (s1 !== 16'(cnt1)) begin bad++; $display("FAIL rnd_stall1 @%0d: got %0d want %0d", n, s1, cnt1); end
            total++; if (v0 !== ev0 || c0 !== ec0) begin bad++; $display("FAIL rnd_out0 @%0d: got v=%0h c=%0h want v=%0h c=%0h", n, v0, c0, ev0, ec0); end
            total++; if (d0 !== md0) begin bad++; $display("FAIL rnd_data0 @%0d: got %0h want %0h", n, d0, md0); end
            total++; if (r0 !== er0) begin bad++; $display("FAIL rnd_ready0 @%0d: got %0h want %0h", n, r0, er0); end
            total++; if (s0 !== 16'(cnt0)) begin bad++; $display("FAIL rnd_stall0 @%0d: got %0d want %0d", n, s0, cnt0); end
            total++; if (v4 !== ev1 || c4 !== ec1 || r4 !== er1) begin bad++; $display("FAIL rnd_out4 @%0d: got v=%0h c=%0h r=%0h want v=%0h c=%0h r=%0h", n, v4, c4, r4, ev1, ec1, er1); end
            total++; if (d4 !== md1) begin bad++; $display("FAIL rnd_data4 @%0d: got %0h want %0h", n, d4, md1); end
            total++; if (s4 !== 4'(cnt4)) begin bad++; $display("FAIL rnd_stall4 @%0d: got %0d want %0d", n, s4, cnt4); end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_single_entry();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
